mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX/MEM stage register (EX_MEM_stage_t) and drives the
//  data-cache request. Stalls the pipeline until the data cache responds, then produces the MEM/WB register (MEM_WB_stage_t).
//  Loads return the raw aligned word. Sign/zero extension is done in WB through regfilemux_sel (lb/lbu/lh/lhu/lw).
// PARAMETERS
//  none (all widths fixed by rv32i_types)
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  rst          in   1    asynchronous, active-high reset
//  ex_mem_i     in   EX_MEM_stage_t  EX/MEM register contents (valid = ctrl_wd.valid)
//  stall_i      in   1    global stall from another source (e.g. I-cache miss); holds MEM/WB
//  dmem_address out  32   word-aligned address = {mar[31:2],2'b00}
//  dmem_read    out  1    read request, held until dmem_resp
//  dmem_write   out  1    write request, held until dmem_resp
//  dmem_wmask   out  4    byte write mask
//  dmem_wdata   out  32   lane-shifted store data
//  dmem_rdata   in   32   read data, valid with dmem_resp
//  dmem_resp    in   1    single-cycle completion pulse
//  mem_stall_o  out  1    1 = freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  mem_wb_o     out  MEM_WB_stage_t  MEM/WB register
// BEHAVIOUR
//  - mem_op = ctrl_wd.valid & (mem_read|mem_write). mem_read and mem_write are never both set.
//  - FSM: IDLE, WAIT, DONE.
//    - IDLE: if mem_op, go to WAIT, or go to DONE if dmem_resp is already seen with stall_i.
//    - WAIT: on dmem_resp & !stall_i go to IDLE. On dmem_resp & stall_i go to DONE.
//    - DONE: when !stall_i, go to IDLE. Any dmem_resp seen in DONE is ignored.
//  - Requests: dmem_read/dmem_write are driven combinationally = mem_op & (state!=DONE). They are never re-issued after a response.
//  - Store lanes (off = mar[1:0]):
//    - sb: wmask = 4'b0001<<off, wdata = rs2<<(8*off)
//    - sh: wmask = 4'b0011<<off, wdata = rs2<<(16*off[1])
//    - sw: wmask = 4'b1111, wdata = rs2
//    - Shifted masks are truncated to 4 bits. No misalignment trap.
//  - On loads, wmask = 0.
//  - mem_stall_o = mem_op & !dmem_resp & (state!=DONE). Latency: one cycle plus cache latency. Zero added cycles for non-memory instructions.
//  - A 32-bit rdata_buf captures dmem_rdata on the response when stall_i is high. In DONE, mdr is sourced from rdata_buf.
//  - MEM/WB update happens when !mem_stall_o & !stall_i:
//    - ctrl_wd, alu_out, cmp_out, mar, u_imm and rd are copied from ex_mem_i.
//    - mdr = load data, or 0 otherwise.
//    - Invalid input produces a bubble (ctrl_wd.valid=0).
//    - Otherwise mem_wb_o holds its value.
//  - Reset: state=IDLE, rdata_buf=0, mem_wb_o all zeros (valid=0). All dmem_* outputs and mem_stall_o are forced to 0 while rst is high.
//    Reset mid-access abandons the request. The cache completes it and its dmem_resp is ignored because state=IDLE with no mem_op.
// CONFIGURATION
//  MEM_STAGE_RVFI_EN defined:
//    - rvfi_mem_addr = dmem_address
//    - rvfi_mem_rmask = 4'b1111 for reads
//    - rvfi_mem_wmask = dmem_wmask
//    - rvfi_mem_wdata = dmem_wdata
//    - rvfi_mem_rdata = mdr
//    - rvfi_pc_wdata is overridden on taken branch/jump with alu_out
//  Undefined: rvfi_d passes through unchanged and the block has no RVFI logic.
// STRUCTURE
//  rv32i_types adds: mem_state_t enum {IDLE,WAIT,DONE} and wmask constants WMASK_B/H/W.
//  Sub-module mem_align (combinational): funct3, mar[1:0], rs2 -> wmask, wdata. Reused by the store path only.
// TESTING
//  1. sw x2=0xDEADBEEF, mar=0x100, resp after 3 cycles:
//     - address 0x100, wmask 1111, wdata 0xDEADBEEF
//     - mem_stall_o high 3 cycles, then MEM/WB valid
//  2. sb rs2=0xA5, mar=0x103 -> address 0x100, wmask 1000, wdata 0xA5000000.
//  3. sh rs2=0x1234, mar=0x202 -> wmask 1100, wdata 0x12340000.
//  4. lw mar=0x40, rdata=0xCAFEF00D, resp coincident with stall_i=1 for 2 cycles:
//     - state DONE, dmem_read drops, no re-issue
//     - MEM/WB mdr=0xCAFEF00D on release
//  5. ALU op (no mem) -> zero stall, MEM/WB updates next edge. Invalid input -> MEM/WB valid=0.
//  6. rst asserted in WAIT -> outputs 0 immediately, stale dmem_resp next cycle ignored, next lw issues normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared RV32I types for the memory-access stage:
//     - stage register layouts EX_MEM_stage_t / MEM_WB_stage_t and the
//       control word and RVFI record they carry
//     - mem_state_t, the data-cache handshake state
//     - byte-lane write mask constants WMASK_B / WMASK_H / WMASK_W
//     - store funct3 encodings and control-transfer opcodes
//   Optional feature macro used by the stage: MEM_STAGE_RVFI_EN.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   // Unshifted write masks for byte, halfword and word stores
   localparam logic [3:0] WMASK_B = 4'b0001;
   localparam logic [3:0] WMASK_H = 4'b0011;
   localparam logic [3:0] WMASK_W = 4'b1111;

   // Store width encodings (funct3)
   localparam logic [2:0] F3_B = 3'b000;
   localparam logic [2:0] F3_H = 3'b001;
   localparam logic [2:0] F3_W = 3'b010;

   // Control-transfer opcodes
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic       valid;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic       mem_read;
      logic       mem_write;
      logic       load_regfile;
      logic [3:0] regfilemux_sel;
   } ctrl_word_t;

   typedef struct packed {
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } rvfi_t;

   typedef struct packed {
      ctrl_word_t  ctrl_wd;
      rvfi_t       rvfi_d;
      logic [31:0] alu_out;
      logic        cmp_out;
      logic [31:0] mar;
      logic [31:0] rs2_out;
      logic [31:0] u_imm;
      logic [4:0]  rd;
   } EX_MEM_stage_t;

   typedef struct packed {
      ctrl_word_t  ctrl_wd;
      rvfi_t       rvfi_d;
      logic [31:0] alu_out;
      logic        cmp_out;
      logic [31:0] mar;
      logic [31:0] mdr;
      logic [31:0] u_imm;
      logic [4:0]  rd;
   } MEM_WB_stage_t;

   // True when the instruction redirects the PC (taken branch, jal, jalr)
   function automatic logic is_redirect(input logic [6:0] opcode, input logic cmp_out);
      return ((opcode == OP_BRANCH) && cmp_out) || (opcode == OP_JAL) || (opcode == OP_JALR);
   endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
//   Combinational store-lane alignment: places rs2 onto the byte lanes
//   selected by the low address bits and produces the matching write mask.
//   Shifted masks are truncated to 4 bits; misaligned accesses are not trapped.
// Ports:
//   funct3_i  in  3   store width (sb/sh/sw)
//   off_i     in  2   byte offset = mar[1:0]
//   rs2_i     in  32  raw store data
//   wmask_o   out 4   byte write mask
//   wdata_o   out 32  lane-shifted store data
// -----------------------------------------------------------------------------
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rs2_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wdata_o
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      wmask_o = '0;
      wdata_o = rs2_i;
      case (funct3_i)
         F3_B: begin
            wmask_o = WMASK_B << off_i;
            wdata_o = rs2_i << {off_i, 3'b000};
         end
         F3_H: begin
            wmask_o = WMASK_H << off_i;
            wdata_o = rs2_i << {off_i[1], 4'b0000};
         end
         F3_W: begin
            wmask_o = WMASK_W;
            wdata_o = rs2_i;
         end
         default: begin
            wmask_o = '0;
            wdata_o = rs2_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 5-stage RV32I pipeline. Issues the data-cache
//   request for the instruction in EX/MEM, stalls until the cache responds and
//   loads the MEM/WB register. Loads return the raw aligned word; extension
//   happens in WB.
// Ports:
//   clk           in   1    clock, rising edge
//   rst           in   1    asynchronous active-high reset
//   ex_mem_i      in   EX_MEM_stage_t   EX/MEM register
//   stall_i       in   1    external stall, holds MEM/WB
//   dmem_address  out  32   word-aligned request address
//   dmem_read     out  1    read request, held until dmem_resp
//   dmem_write    out  1    write request, held until dmem_resp
//   dmem_wmask    out  4    byte write mask (0 on loads)
//   dmem_wdata    out  32   lane-shifted store data
//   dmem_rdata    in   32   read data, valid with dmem_resp
//   dmem_resp     in   1    single-cycle completion pulse
//   mem_stall_o   out  1    freeze upstream pipeline this cycle
//   mem_wb_o      out  MEM_WB_stage_t   MEM/WB register
// Configuration:
//   MEM_STAGE_RVFI_EN  fill the RVFI memory fields and PC redirect in MEM/WB;
//                      otherwise rvfi_d passes through untouched.
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  EX_MEM_stage_t ex_mem_i,
   input  logic          stall_i,
   output logic [31:0]   dmem_address,
   output logic          dmem_read,
   output logic          dmem_write,
   output logic [3:0]    dmem_wmask,
   output logic [31:0]   dmem_wdata,
   input  logic [31:0]   dmem_rdata,
   input  logic          dmem_resp,
   output logic          mem_stall_o,
   output MEM_WB_stage_t mem_wb_o
);

   mem_state_t    state_q;
   logic [31:0]   rdata_buf_q;
   MEM_WB_stage_t mem_wb_q;
   MEM_WB_stage_t mem_wb_d;

   logic        is_load;
   logic        is_store;
   logic        mem_op;
   logic        not_done;
   logic        resp_accept;
   logic        wb_en;
   logic [31:0] load_data;
   logic [3:0]  align_wmask;
   logic [31:0] align_wdata;

   mem_align u_align (
      .funct3_i (ex_mem_i.ctrl_wd.funct3),
      .off_i    (ex_mem_i.mar[1:0]),
      .rs2_i    (ex_mem_i.rs2_out),
      .wmask_o  (align_wmask),
      .wdata_o  (align_wdata)
   );

   assign is_load  = ex_mem_i.ctrl_wd.valid & ex_mem_i.ctrl_wd.mem_read;
   assign is_store = ex_mem_i.ctrl_wd.valid & ex_mem_i.ctrl_wd.mem_write;
   assign mem_op   = is_load | is_store;

   // Once the response has been taken (DONE) the request is dropped so it is never re-issued.
   assign not_done    = (state_q != DONE);
   assign resp_accept = mem_op & dmem_resp & not_done;

   // Cache interface; everything is forced low while reset is held.
   assign dmem_read    = ~rst & is_load  & not_done;
   assign dmem_write   = ~rst & is_store & not_done;
   assign dmem_address = rst ? '0 : {ex_mem_i.mar[31:2], 2'b00};
   assign dmem_wmask   = (~rst & is_store) ? align_wmask : '0;
   assign dmem_wdata   = rst ? '0 : align_wdata;

   assign mem_stall_o = ~rst & mem_op & ~dmem_resp & not_done;
   assign wb_en       = ~mem_stall_o & ~stall_i;

   // A response taken under stall_i is replayed from the buffer once stall_i clears.
   assign load_data = (state_q == DONE) ? rdata_buf_q : dmem_rdata;

   always_comb begin
      mem_wb_d = '0;
      if (ex_mem_i.ctrl_wd.valid) begin
         mem_wb_d.ctrl_wd = ex_mem_i.ctrl_wd;
         mem_wb_d.rvfi_d  = ex_mem_i.rvfi_d;
         mem_wb_d.alu_out = ex_mem_i.alu_out;
         mem_wb_d.cmp_out = ex_mem_i.cmp_out;
         mem_wb_d.mar     = ex_mem_i.mar;
         mem_wb_d.u_imm   = ex_mem_i.u_imm;
         mem_wb_d.rd      = ex_mem_i.rd;
         mem_wb_d.mdr     = is_load ? load_data : '0;
`ifdef MEM_STAGE_RVFI_EN
         mem_wb_d.rvfi_d.mem_addr  = dmem_address;
         mem_wb_d.rvfi_d.mem_rmask = is_load ? 4'b1111 : 4'b0000;
         mem_wb_d.rvfi_d.mem_wmask = dmem_wmask;
         mem_wb_d.rvfi_d.mem_wdata = dmem_wdata;
         mem_wb_d.rvfi_d.mem_rdata = mem_wb_d.mdr;
         if (is_redirect(ex_mem_i.ctrl_wd.opcode, ex_mem_i.cmp_out)) begin
            mem_wb_d.rvfi_d.pc_wdata = ex_mem_i.alu_out;
         end
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rdata_buf_q <= '0;
         mem_wb_q    <= '0;
      end else begin
         if (resp_accept && stall_i) begin
            rdata_buf_q <= dmem_rdata;
         end
         if (wb_en) begin
            mem_wb_q <= mem_wb_d;
         end
         case (state_q)
            IDLE: begin
               if (mem_op) begin
                  if (!dmem_resp) begin
                     state_q <= WAIT;
                  end else if (stall_i) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            WAIT: begin
               if (dmem_resp) begin
                  state_q <= stall_i ? DONE : IDLE;
               end
            end
            DONE: begin
               // Late responses here are ignored; only stall_i releases the state.
               if (!stall_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_wb_o = mem_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Directed self-checking bench for mem_stage: stores of each width, a load
//   whose response coincides with an external stall, non-memory and invalid
//   instructions, and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic          clk;
   logic          rst;
   EX_MEM_stage_t ex_mem;
   logic          stall_i;
   logic [31:0]   dmem_address;
   logic          dmem_read;
   logic          dmem_write;
   logic [3:0]    dmem_wmask;
   logic [31:0]   dmem_wdata;
   logic [31:0]   dmem_rdata;
   logic          dmem_resp;
   logic          mem_stall;
   MEM_WB_stage_t mem_wb;

   int checks   = 0;
   int failures = 0;

   mem_stage dut (
      .clk          (clk),
      .rst          (rst),
      .ex_mem_i     (ex_mem),
      .stall_i      (stall_i),
      .dmem_address (dmem_address),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_wmask   (dmem_wmask),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .mem_stall_o  (mem_stall),
      .mem_wb_o     (mem_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive inputs 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic EX_MEM_stage_t mk(input logic v, input logic rd_en, input logic wr_en,
                                         input logic [2:0] f3, input logic [31:0] mar,
                                         input logic [31:0] rs2, input logic [31:0] alu,
                                         input logic [4:0] rdi);
      EX_MEM_stage_t e;
      e = '0;
      e.ctrl_wd.valid        = v;
      e.ctrl_wd.mem_read     = rd_en;
      e.ctrl_wd.mem_write    = wr_en;
      e.ctrl_wd.funct3       = f3;
      e.ctrl_wd.opcode       = rd_en ? 7'b0000011 : (wr_en ? 7'b0100011 : 7'b0010011);
      e.ctrl_wd.load_regfile = ~wr_en;
      e.mar     = mar;
      e.rs2_out = rs2;
      e.alu_out = alu;
      e.rd      = rdi;
      return e;
   endfunction

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset with a valid store already presented
      rst        = 1'b1;
      stall_i    = 1'b0;
      dmem_resp  = 1'b0;
      dmem_rdata = '0;
      ex_mem     = mk(1'b1, 1'b0, 1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 5'd0);
      #2;
      check("rst_write",   {31'b0, dmem_write}, 32'd0);
      check("rst_addr",    dmem_address, 32'd0);
      check("rst_wmask",   {28'b0, dmem_wmask}, 32'd0);
      check("rst_stall",   {31'b0, mem_stall}, 32'd0);
      check("rst_wbvalid", {31'b0, mem_wb.ctrl_wd.valid}, 32'd0);
      step();
      step();

      // ---------------- 1. sw, response after 3 stalled cycles
      rst = 1'b0;
      #1;
      check("sw_addr",  dmem_address, 32'h0000_0100);
      check("sw_wmask", {28'b0, dmem_wmask}, 32'h0000_000F);
      check("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         check("sw_stall_hi", {31'b0, mem_stall}, 32'd1);
         check("sw_write_hi", {31'b0, dmem_write}, 32'd1);
         step();
      end
      dmem_resp = 1'b1;
      #1;
      check("sw_resp_stall", {31'b0, mem_stall}, 32'd0);
      check("sw_wb_hold",    {31'b0, mem_wb.ctrl_wd.valid}, 32'd0);
      step();

      // ---------------- 2. sb, immediate response
      ex_mem = mk(1'b1, 1'b0, 1'b1, F3_B, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0103, 5'd0);
      #1;
      check("sw_wb_valid", {31'b0, mem_wb.ctrl_wd.valid}, 32'd1);
      check("sw_wb_mar",   mem_wb.mar, 32'h0000_0100);
      check("sw_wb_mdr",   mem_wb.mdr, 32'd0);
      check("sb_addr",     dmem_address, 32'h0000_0100);
      check("sb_wmask",    {28'b0, dmem_wmask}, 32'h0000_0008);
      check("sb_wdata",    dmem_wdata, 32'hA500_0000);
      check("sb_stall",    {31'b0, mem_stall}, 32'd0);
      step();

      // ---------------- 3. sh, immediate response
      ex_mem = mk(1'b1, 1'b0, 1'b1, F3_H, 32'h0000_0202, 32'h0000_1234, 32'h0000_0202, 5'd0);
      #1;
      check("sb_wb_mar", mem_wb.mar, 32'h0000_0103);
      check("sh_wmask",  {28'b0, dmem_wmask}, 32'h0000_000C);
      check("sh_wdata",  dmem_wdata, 32'h1234_0000);
      step();

      // ---------------- 4. lw, response coincides with stall_i for 2 cycles
      dmem_resp = 1'b0;
      ex_mem = mk(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0040, 32'd0, 32'h0000_0040, 5'd5);
      #1;
      check("sh_wb_mar", mem_wb.mar, 32'h0000_0202);
      check("lw_read",   {31'b0, dmem_read}, 32'd1);
      check("lw_addr",   dmem_address, 32'h0000_0040);
      check("lw_wmask",  {28'b0, dmem_wmask}, 32'd0);
      check("lw_stall",  {31'b0, mem_stall}, 32'd1);
      step();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      stall_i    = 1'b1;
      #1;
      check("lw_resp_stall", {31'b0, mem_stall}, 32'd0);
      check("lw_resp_read",  {31'b0, dmem_read}, 32'd1);
      step();
      // DONE: a stray response here must be ignored
      dmem_rdata = 32'hBAD0_BAD0;
      #1;
      check("done_read",    {31'b0, dmem_read}, 32'd0);
      check("done_stall",   {31'b0, mem_stall}, 32'd0);
      check("done_wb_hold", mem_wb.mar, 32'h0000_0202);
      step();
      dmem_resp  = 1'b0;
      dmem_rdata = 32'h1111_1111;
      stall_i    = 1'b0;
      #1;
      check("release_read", {31'b0, dmem_read}, 32'd0);
      step();

      // ---------------- 5. ALU op with stall_i, then without, then invalid
      ex_mem  = mk(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h0000_55AA, 5'd3);
      stall_i = 1'b1;
      #1;
      check("lw_wb_mdr",   mem_wb.mdr, 32'hCAFE_F00D);
      check("lw_wb_rd",    {27'b0, mem_wb.rd}, 32'd5);
      check("lw_wb_valid", {31'b0, mem_wb.ctrl_wd.valid}, 32'd1);
      check("alu_stall",   {31'b0, mem_stall}, 32'd0);
      check("alu_noreq",   {30'b0, dmem_read, dmem_write}, 32'd0);
      step();
      stall_i = 1'b0;
      #1;
      check("stall_i_hold", mem_wb.alu_out, 32'h0000_0040);
      step();
      ex_mem = mk(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h0000_0777, 5'd4);
      #1;
      check("alu_wb_alu", mem_wb.alu_out, 32'h0000_55AA);
      check("alu_wb_mdr", mem_wb.mdr, 32'd0);
      step();

      // ---------------- 6. reset while waiting on a load
      ex_mem = mk(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0080, 32'd0, 32'h0000_0080, 5'd6);
      #1;
      check("bubble_valid", {31'b0, mem_wb.ctrl_wd.valid}, 32'd0);
      check("lw2_read",     {31'b0, dmem_read}, 32'd1);
      step();
      check("lw2_wait_stall", {31'b0, mem_stall}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_read",  {31'b0, dmem_read}, 32'd0);
      check("rst_mid_addr",  dmem_address, 32'd0);
      check("rst_mid_stall", {31'b0, mem_stall}, 32'd0);
      step();
      rst        = 1'b0;
      ex_mem     = mk(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hBADB_AD00;
      #1;
      check("stale_stall", {31'b0, mem_stall}, 32'd0);
      check("stale_read",  {31'b0, dmem_read}, 32'd0);
      step();
      dmem_resp = 1'b0;
      ex_mem    = mk(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0084, 32'd0, 32'h0000_0084, 5'd7);
      #1;
      check("stale_wb_valid", {31'b0, mem_wb.ctrl_wd.valid}, 32'd0);
      check("lw3_read",       {31'b0, dmem_read}, 32'd1);
      check("lw3_addr",       dmem_address, 32'h0000_0084);
      check("lw3_stall",      {31'b0, mem_stall}, 32'd1);
      step();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'h600D_F00D;
      #1;
      check("lw3_resp_stall", {31'b0, mem_stall}, 32'd0);
      step();
      dmem_resp = 1'b0;
      ex_mem    = mk(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);
      #1;
      check("lw3_wb_mdr",   mem_wb.mdr, 32'h600D_F00D);
      check("lw3_wb_rd",    {27'b0, mem_wb.rd}, 32'd7);
      check("lw3_wb_valid", {31'b0, mem_wb.ctrl_wd.valid}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
